// File: rtl/xor_parity_pkg.sv
// Shared definitions for the framed parity accumulator: FSM encoding and
// parameter limits.
package xor_parity_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int FRAME_LEN_MIN = 2;
    localparam int FRAME_LEN_MAX = 255;
    localparam int IDX_W         = 8;

endpackage

// File: rtl/xor_parity_frame_if.sv
// Bit-stream input and parity-result output handshakes of xor_parity_frame.
// par_err exists only when PARITY_CHECK_EN is defined.
interface xor_parity_frame_if #(
    parameter int CNT_W = 8
);

    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             par_out;
    logic             par_valid;
    logic             par_ready;
    logic [CNT_W-1:0] frame_cnt;
`ifdef PARITY_CHECK_EN
    logic             par_err;

    modport master (
        output bit_in, bit_valid, par_ready,
        input  bit_ready, par_out, par_valid, frame_cnt, par_err
    );

    modport slave (
        input  bit_in, bit_valid, par_ready,
        output bit_ready, par_out, par_valid, frame_cnt, par_err
    );
`else
    modport master (
        output bit_in, bit_valid, par_ready,
        input  bit_ready, par_out, par_valid, frame_cnt
    );

    modport slave (
        input  bit_in, bit_valid, par_ready,
        output bit_ready, par_out, par_valid, frame_cnt
    );
`endif

endinterface

// File: rtl/parity_accum_cell.sv
// One-bit XOR accumulator: gate-level fold plus a flop with async clear,
// synchronous clear (priority) and enable.
module parity_accum_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q,
    output logic fold
);

    xor u_xor (fold, q, d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= fold;
        end
    end

endmodule

// File: rtl/xor_parity_frame.sv
// Folds each FRAME_LEN-bit frame of the XOR gate output into an even-parity bit
// with valid/ready handoff and a frame counter. Option: PARITY_CHECK_EN.
module xor_parity_frame
    import xor_parity_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input logic          clk,
    input logic          rst_n,
    xor_parity_frame_if.slave bus
);

    generate
        if (FRAME_LEN < FRAME_LEN_MIN || FRAME_LEN > FRAME_LEN_MAX) begin : g_bad_frame_len
            $error("xor_parity_frame: FRAME_LEN out of range");
        end
    endgenerate

    // With the check enabled the received parity bit occupies one extra slot.
`ifdef PARITY_CHECK_EN
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN);
`else
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
`endif

    state_t           state_q;
    logic             bit_ready_q;
    logic             par_valid_q;
    logic             par_out_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             acc;
    logic             fold;
    logic             accept;
    logic             last_bit;
`ifdef PARITY_CHECK_EN
    logic             par_err_q;
`endif

    assign accept   = bus.bit_valid & bit_ready_q;
    assign last_bit = accept && (idx_q == LAST);

    parity_accum_cell u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (last_bit),
        .en    (accept),
        .d     (bus.bit_in),
        .q     (acc),
        .fold  (fold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            bit_ready_q <= 1'b1;
            par_valid_q <= 1'b0;
            par_out_q   <= 1'b0;
            frame_cnt_q <= '0;
            idx_q       <= '0;
`ifdef PARITY_CHECK_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (last_bit) begin
                        state_q     <= HOLD;
                        bit_ready_q <= 1'b0;
                        par_valid_q <= 1'b1;
                        idx_q       <= '0;
`ifdef PARITY_CHECK_EN
                        // Incoming bit is the received parity: keep it out of par_out.
                        par_out_q   <= acc;
                        par_err_q   <= fold;
`else
                        par_out_q   <= fold;
`endif
                    end else if (accept) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.par_ready) begin
                        state_q     <= COLLECT;
                        bit_ready_q <= 1'b1;
                        par_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    bit_ready_q <= 1'b1;
                    par_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bit_ready = bit_ready_q;
    assign bus.par_valid = par_valid_q;
    assign bus.par_out   = par_out_q;
    assign bus.frame_cnt = frame_cnt_q;
`ifdef PARITY_CHECK_EN
    assign bus.par_err   = par_err_q;
`endif

endmodule
